n64rgb_cfg_sched: RTL and testbench
===================================

N64RGB_CFG_SCHED -- requirements
Module: n64rgb_cfg_sched

Interface
REQ-001 Parameter HOLDOFF, default 16: idle cycles enforced after each commit; legal 1..65535.
REQ-002 Parameter RST_LEN, default 1024: DRV_RST pulse length in VCLK cycles; legal 1..65535.
REQ-003 VCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 BOOT_REQ/SW_REQ/IGR_REQ  in  1 each  request from boot-default loader / switch-toggle detector / IGR decoder.
REQ-006 BOOT_ID/SW_ID/IGR_ID  in  2 each  target: 0 = 15-bit mode, 1 = deblur, 2 = console reset, 3 = reserved.
REQ-007 BOOT_VAL/SW_VAL/IGR_VAL  in  1 each  value to write; 1 = feature on.
REQ-008 EN_RST  in  1  enables execution of ID 2 requests.
REQ-009 BOOT_ACK/SW_ACK/IGR_ACK  out  1 each  one-cycle grant-complete pulse.
REQ-010 n15bit_o  out  1  active-low 15-bit mode enable.
REQ-011 nDeBlur_o  out  1  active-low deblur enable.
REQ-012 DRV_RST  out  1  console reset drive, active-high.
REQ-013 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, COMMIT, HOLD, RSTP; registered; unreachable encodings go to IDLE next edge.
REQ-015 Requester rule: REQ held high with ID/VAL stable until its ACK is seen; REQ deasserted no later than the cycle after ACK.
REQ-016 IDLE, any REQ high at edge: latch winner index, ID, VAL; go COMMIT.
REQ-017 Fixed priority BOOT > SW > IGR; losers stay pending, not acked; no fairness guaranteed.
REQ-018 COMMIT edge, ID 0: n15bit_o <= ~VAL; winner ACK <= 1; go HOLD, hold counter <= HOLDOFF-1.
REQ-019 COMMIT edge, ID 1: nDeBlur_o <= ~VAL; winner ACK <= 1; go HOLD, counter <= HOLDOFF-1.
REQ-020 COMMIT edge, ID 2, EN_RST=1: DRV_RST <= 1; winner ACK <= 1; go RSTP, counter <= RST_LEN-1; VAL ignored.
REQ-021 COMMIT edge, ID 2 with EN_RST=0, or ID 3: no output change; winner ACK <= 1; go HOLD.
REQ-022 Latency: REQ sampled at edge N -> output change and ACK both visible after edge N+1.
REQ-023 ACK high exactly one cycle; at most one ACK high in any cycle.
REQ-024 HOLD: counter decrements per cycle; at 0, next edge goes IDLE; REQs ignored throughout.
REQ-025 RSTP: DRV_RST high; counter decrements; at 0, next edge DRV_RST <= 0 and go HOLD with counter <= HOLDOFF-1.
REQ-026 DRV_RST high for exactly RST_LEN cycles per executed reset command.
REQ-027 Requests arriving in COMMIT/HOLD/RSTP stay pending; serviced by priority on return to IDLE.
REQ-028 Same ID written twice: second commit rewrites same value; still acked; no glitch on output.
REQ-029 EN_RST sampled only in COMMIT; change during RSTP does not shorten pulse.
REQ-030 Counters 16-bit unsigned; no wrap: a counter at 0 never decrements.

Reset
REQ-031 RST high: state IDLE, n15bit_o=1, nDeBlur_o=1, DRV_RST=0, all ACK=0, BUSY=0, counters 0, latched winner cleared; immediate, no clock needed.
REQ-032 RST mid-RSTP drops DRV_RST asynchronously; the interrupted command is not re-executed.
REQ-033 First edge after RST release with a REQ high behaves as IDLE (REQ-016).

Verification
REQ-034 SW_REQ=1, SW_ID=1, SW_VAL=1 at edge N -> nDeBlur_o=0 and SW_ACK=1 after edge N+1; BUSY high HOLDOFF+1 cycles total.
REQ-035 BOOT_REQ (ID0,VAL1) and IGR_REQ (ID1,VAL1) same edge -> BOOT served first (n15bit_o=0); IGR acked HOLDOFF+2 cycles later, nDeBlur_o=0.
REQ-036 IGR ID 2, EN_RST=1, RST_LEN=1024 -> DRV_RST high exactly 1024 cycles, then HOLDOFF-cycle HOLD, then IDLE.
REQ-037 IGR ID 2, EN_RST=0 -> IGR_ACK pulses, DRV_RST stays 0, n15bit_o/nDeBlur_o unchanged.
REQ-038 RST asserted 100 cycles into RSTP -> DRV_RST=0 same cycle, all outputs at reset values, no further pulse after release.
REQ-039 Randomized REQ traffic, 10^5 cycles -> every REQ acked once, never two ACKs in one cycle, outputs match reference model.

Source files
------------

// File: rtl/n64rgb_cfg_sched.sv
// Configuration write scheduler: arbitrates boot/switch/IGR requests, commits one
// setting at a time, enforces a hold-off gap and stretches console-reset commands.
module n64rgb_cfg_sched #(
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned RST_LEN = 1024
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       BOOT_REQ,
    input  logic [1:0] BOOT_ID,
    input  logic       BOOT_VAL,
    input  logic       SW_REQ,
    input  logic [1:0] SW_ID,
    input  logic       SW_VAL,
    input  logic       IGR_REQ,
    input  logic [1:0] IGR_ID,
    input  logic       IGR_VAL,
    input  logic       EN_RST,
    output logic       BOOT_ACK,
    output logic       SW_ACK,
    output logic       IGR_ACK,
    output logic       n15bit_o,
    output logic       nDeBlur_o,
    output logic       DRV_RST,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RSTP   = 2'd3
    } state_t;

    localparam logic [1:0]  ID_15BIT  = 2'd0;
    localparam logic [1:0]  ID_DEBLUR = 2'd1;
    localparam logic [1:0]  ID_CRST   = 2'd2;
    localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF - 1);
    localparam logic [15:0] RST_INIT  = 16'(RST_LEN - 1);

    // Requester one-hot ordering shared by winner latch and ACK vector: {BOOT, SW, IGR}.
    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_win, w_win_nxt;
    logic [1:0]  r_id, w_id_nxt;
    logic        r_val, w_val_nxt;
    logic [2:0]  r_ack, w_ack_nxt;
    logic        r_n15bit, w_n15bit_nxt;
    logic        r_ndeblur, w_ndeblur_nxt;
    logic        r_drv_rst, w_drv_rst_nxt;

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_win_nxt     = r_win;
        w_id_nxt      = r_id;
        w_val_nxt     = r_val;
        w_ack_nxt     = 3'b000;
        w_n15bit_nxt  = r_n15bit;
        w_ndeblur_nxt = r_ndeblur;
        w_drv_rst_nxt = r_drv_rst;

        case (r_state)
            ST_IDLE: begin
                if (BOOT_REQ) begin
                    w_win_nxt   = 3'b100;
                    w_id_nxt    = BOOT_ID;
                    w_val_nxt   = BOOT_VAL;
                    w_state_nxt = ST_COMMIT;
                end else if (SW_REQ) begin
                    w_win_nxt   = 3'b010;
                    w_id_nxt    = SW_ID;
                    w_val_nxt   = SW_VAL;
                    w_state_nxt = ST_COMMIT;
                end else if (IGR_REQ) begin
                    w_win_nxt   = 3'b001;
                    w_id_nxt    = IGR_ID;
                    w_val_nxt   = IGR_VAL;
                    w_state_nxt = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                w_ack_nxt   = r_win;
                w_win_nxt   = 3'b000;
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = HOLD_INIT;
                case (r_id)
                    ID_15BIT:  w_n15bit_nxt  = ~r_val;
                    ID_DEBLUR: w_ndeblur_nxt = ~r_val;
                    ID_CRST: begin
                        // Reset commands run only when enabled; otherwise acked as a no-op.
                        if (EN_RST) begin
                            w_drv_rst_nxt = 1'b1;
                            w_state_nxt   = ST_RSTP;
                            w_cnt_nxt     = RST_INIT;
                        end
                    end
                    default: ;
                endcase
            end

            ST_HOLD: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            ST_RSTP: begin
                if (r_cnt == 16'd0) begin
                    w_drv_rst_nxt = 1'b0;
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = HOLD_INIT;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: RST clears every register asynchronously, so DRV_RST drops without a clock.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 16'd0;
            r_win     <= 3'b000;
            r_id      <= 2'd0;
            r_val     <= 1'b0;
            r_ack     <= 3'b000;
            r_n15bit  <= 1'b1;
            r_ndeblur <= 1'b1;
            r_drv_rst <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_win     <= w_win_nxt;
            r_id      <= w_id_nxt;
            r_val     <= w_val_nxt;
            r_ack     <= w_ack_nxt;
            r_n15bit  <= w_n15bit_nxt;
            r_ndeblur <= w_ndeblur_nxt;
            r_drv_rst <= w_drv_rst_nxt;
        end
    end

    assign BOOT_ACK  = r_ack[2];
    assign SW_ACK    = r_ack[1];
    assign IGR_ACK   = r_ack[0];
    assign n15bit_o  = r_n15bit;
    assign nDeBlur_o = r_ndeblur;
    assign DRV_RST   = r_drv_rst;
    assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_n64rgb_cfg_sched.sv
// Directed bench for n64rgb_cfg_sched: table of single commands plus hand-written
// priority, reset-during-pulse and request-at-reset-release sequences.
module tb_n64rgb_cfg_sched;

    localparam int HOLDOFF = 16;
    localparam int RST_LEN = 1024;

    logic       VCLK = 1'b0;
    logic       RST;
    logic       BOOT_REQ, SW_REQ, IGR_REQ;
    logic [1:0] BOOT_ID, SW_ID, IGR_ID;
    logic       BOOT_VAL, SW_VAL, IGR_VAL;
    logic       EN_RST;
    logic       BOOT_ACK, SW_ACK, IGR_ACK;
    logic       n15bit_o, nDeBlur_o, DRV_RST, BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    n64rgb_cfg_sched #(.HOLDOFF(HOLDOFF), .RST_LEN(RST_LEN)) dut (
        .VCLK(VCLK), .RST(RST),
        .BOOT_REQ(BOOT_REQ), .BOOT_ID(BOOT_ID), .BOOT_VAL(BOOT_VAL),
        .SW_REQ(SW_REQ), .SW_ID(SW_ID), .SW_VAL(SW_VAL),
        .IGR_REQ(IGR_REQ), .IGR_ID(IGR_ID), .IGR_VAL(IGR_VAL),
        .EN_RST(EN_RST),
        .BOOT_ACK(BOOT_ACK), .SW_ACK(SW_ACK), .IGR_ACK(IGR_ACK),
        .n15bit_o(n15bit_o), .nDeBlur_o(nDeBlur_o), .DRV_RST(DRV_RST), .BUSY(BUSY)
    );

    always #5 VCLK = ~VCLK;

    typedef struct {
        string      tag;
        int         src;      // 0 boot, 1 sw, 2 igr
        logic [1:0] id;
        logic       val;
        logic       en;
        logic       exp_n15;
        logic       exp_ndb;
        int         exp_drv;  // DRV_RST high cycles
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_req(input int src, input logic req, input logic [1:0] id, input logic val);
        case (src)
            0: begin BOOT_REQ = req; BOOT_ID = id; BOOT_VAL = val; end
            1: begin SW_REQ = req; SW_ID = id; SW_VAL = val; end
            default: begin IGR_REQ = req; IGR_ID = id; IGR_VAL = val; end
        endcase
    endtask

    function automatic logic [2:0] acks();
        return {BOOT_ACK, SW_ACK, IGR_ACK};
    endfunction

    // Issue one request from IDLE and follow it until BUSY falls.
    task automatic run_cmd(input vec_t v);
        int busy_cnt, drv_cnt, extra_ack, chg;
        EN_RST = v.en;
        set_req(v.src, 1'b1, v.id, v.val);
        @(negedge VCLK);
        check({v.tag, "_noack_yet"}, 32'(acks()), 32'd0);
        busy_cnt = int'(BUSY);
        drv_cnt  = int'(DRV_RST);
        @(negedge VCLK);
        check({v.tag, "_ack"}, 32'(acks()), 32'(3'b100 >> v.src));
        check({v.tag, "_n15"}, 32'(n15bit_o), 32'(v.exp_n15));
        check({v.tag, "_ndb"}, 32'(nDeBlur_o), 32'(v.exp_ndb));
        busy_cnt += int'(BUSY);
        drv_cnt  += int'(DRV_RST);
        set_req(v.src, 1'b0, v.id, v.val);
        EN_RST = 1'b0;  // must not shorten a running pulse
        extra_ack = 0;
        chg = 0;
        for (int i = 0; i < 3000 && BUSY; i++) begin
            @(negedge VCLK);
            busy_cnt += int'(BUSY);
            drv_cnt  += int'(DRV_RST);
            if (acks() != 3'b000) extra_ack++;
            if (n15bit_o != v.exp_n15 || nDeBlur_o != v.exp_ndb) chg++;
        end
        check({v.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_drv + HOLDOFF + 1));
        check({v.tag, "_drv_cycles"}, 32'(drv_cnt), 32'(v.exp_drv));
        check({v.tag, "_extra_ack"}, 32'(extra_ack), 32'd0);
        check({v.tag, "_out_glitch"}, 32'(chg), 32'd0);
    endtask

    initial begin
        int boot_t, igr_t, dual, n15_at_boot, ndb_at_boot, ndb_at_igr, drv_cnt, busy_cnt;

        vecs[0] = '{"sw_deblur_on",   1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{"boot_15bit_on",  0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{"boot_15bit_rep", 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{"igr_rst_dis",    2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{"igr_reserved",   2, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{"sw_15bit_off",   1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[6] = '{"igr_deblur_off", 2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[7] = '{"igr_rst_en",     2, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, RST_LEN};
        vecs[8] = '{"boot_rst_val0",  0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, RST_LEN};

        RST = 1'b1;
        EN_RST = 1'b0;
        set_req(0, 1'b0, 2'd0, 1'b0);
        set_req(1, 1'b0, 2'd0, 1'b0);
        set_req(2, 1'b0, 2'd0, 1'b0);
        #1;
        check("reset_n15", 32'(n15bit_o), 32'd1);
        check("reset_ndb", 32'(nDeBlur_o), 32'd1);
        check("reset_drv", 32'(DRV_RST), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_acks", 32'(acks()), 32'd0);
        repeat (3) @(negedge VCLK);
        RST = 1'b0;
        @(negedge VCLK);

        for (int k = 0; k < 9; k++) run_cmd(vecs[k]);

        // BOOT and IGR together: BOOT wins, IGR waits out the hold-off
        BOOT_REQ = 1'b1; BOOT_ID = 2'd0; BOOT_VAL = 1'b1;
        IGR_REQ  = 1'b1; IGR_ID  = 2'd1; IGR_VAL  = 1'b1;
        boot_t = -1; igr_t = -1; dual = 0;
        n15_at_boot = -1; ndb_at_boot = -1; ndb_at_igr = -1;
        for (int t = 1; t <= 200; t++) begin
            @(negedge VCLK);
            if (BOOT_ACK && IGR_ACK) dual++;
            if (BOOT_ACK) begin
                boot_t = t; n15_at_boot = int'(n15bit_o); ndb_at_boot = int'(nDeBlur_o);
                BOOT_REQ = 1'b0;
            end
            if (IGR_ACK) begin
                igr_t = t; ndb_at_igr = int'(nDeBlur_o);
                IGR_REQ = 1'b0;
            end
            if (igr_t > 0 && !BUSY) break;
        end
        check("prio_boot_ack_cycle", 32'(boot_t), 32'd2);
        check("prio_igr_ack_cycle", 32'(igr_t), 32'(2 + HOLDOFF + 2));
        check("prio_dual_ack", 32'(dual), 32'd0);
        check("prio_n15_at_boot", 32'(n15_at_boot), 32'd0);
        check("prio_ndb_at_boot", 32'(ndb_at_boot), 32'd1);
        check("prio_ndb_at_igr", 32'(ndb_at_igr), 32'd0);
        check("prio_idle_after", 32'(BUSY), 32'd0);

        // Reset 100 cycles into a console-reset pulse
        EN_RST = 1'b1;
        IGR_REQ = 1'b1; IGR_ID = 2'd2; IGR_VAL = 1'b0;
        @(negedge VCLK);
        @(negedge VCLK);
        check("rstp_ack", 32'(IGR_ACK), 32'd1);
        IGR_REQ = 1'b0;
        repeat (100) @(negedge VCLK);
        check("rstp_drv_before", 32'(DRV_RST), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rstp_drv_async", 32'(DRV_RST), 32'd0);
        check("rstp_busy_async", 32'(BUSY), 32'd0);
        check("rstp_n15_async", 32'(n15bit_o), 32'd1);
        check("rstp_ndb_async", 32'(nDeBlur_o), 32'd1);
        @(negedge VCLK);
        RST = 1'b0;
        drv_cnt = 0; busy_cnt = 0;
        repeat (1100) begin
            @(negedge VCLK);
            drv_cnt  += int'(DRV_RST);
            busy_cnt += int'(BUSY);
        end
        check("rstp_no_repulse", 32'(drv_cnt), 32'd0);
        check("rstp_stays_idle", 32'(busy_cnt), 32'd0);

        // Request already high when reset is released
        RST = 1'b1;
        EN_RST = 1'b0;
        SW_REQ = 1'b1; SW_ID = 2'd1; SW_VAL = 1'b1;
        @(negedge VCLK);
        RST = 1'b0;
        @(negedge VCLK);
        check("rel_busy", 32'(BUSY), 32'd1);
        check("rel_noack_yet", 32'(acks()), 32'd0);
        @(negedge VCLK);
        check("rel_sw_ack", 32'(acks()), 32'(3'b010));
        check("rel_ndb", 32'(nDeBlur_o), 32'd0);
        SW_REQ = 1'b0;
        for (int i = 0; i < 100 && BUSY; i++) @(negedge VCLK);
        check("rel_idle_after", 32'(BUSY), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
